// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the shared data RAM port.
// Handles sized/extended loads, read-modify-write sub-word stores and access errors.
module dmem_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RAM_BASE = ADDRESS_WIDTH'(32'h0000_1000),
  parameter logic [ADDRESS_WIDTH-1:0] RAM_TOP  = ADDRESS_WIDTH'(32'h0000_1FFF)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic                     req0_we,
  input  logic [1:0]               req0_size,
  input  logic                     req0_uns,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic [31:0]              req0_wdata,
  output logic                     rsp0_valid,
  output logic [31:0]              rsp0_rdata,
  output logic                     rsp0_err,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic                     req1_we,
  input  logic [1:0]               req1_size,
  input  logic                     req1_uns,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  input  logic [31:0]              req1_wdata,
  output logic                     rsp1_valid,
  output logic [31:0]              rsp1_rdata,
  output logic                     rsp1_err,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [31:0]              ram_wdata,
  input  logic [31:0]              ram_rdata
);

  localparam int unsigned EW = ADDRESS_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t                   state_q, state_d;
  logic                     last_grant_q, grant_q;
  logic                     we_q, uns_q, err_q;
  logic [1:0]               size_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [31:0]              wdata_q, merge_q, rdata_q;

  logic                     any_valid_c, grant_c, accept_c, err_c;
  logic [EW-1:0]            last_c;
  logic [31:0]              load_c;

  assign any_valid_c = req0_valid | req1_valid;
  // Under contention the requester that did not win last time gets the port.
  assign grant_c     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign accept_c    = (state_q == IDLE) & any_valid_c;
  assign ram_addr    = addr_q;

  // Alignment, size and window check on the latched request.
  always_comb begin
    last_c = {1'b0, addr_q};
    if (size_q == 2'b10)      last_c = {1'b0, addr_q} + EW'(3);
    else if (size_q == 2'b01) last_c = {1'b0, addr_q} + EW'(1);
    err_c = (size_q == 2'b11)
          | ((size_q == 2'b01) & addr_q[0])
          | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00))
          | (addr_q < RAM_BASE)
          | (last_c > {1'b0, RAM_TOP});
  end

  always_comb begin
    case (size_q)
      2'b00:   load_c = uns_q ? {24'h0, ram_rdata[7:0]}  : {{24{ram_rdata[7]}},  ram_rdata[7:0]};
      2'b01:   load_c = uns_q ? {16'h0, ram_rdata[15:0]} : {{16{ram_rdata[15]}}, ram_rdata[15:0]};
      default: load_c = ram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid_c) state_d = ACCESS;
      ACCESS:  state_d = (!err_c && we_q && size_q != 2'b10) ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    ram_we     = 1'b0;
    ram_wdata  = 32'h0;
    rsp0_valid = 1'b0;
    rsp0_rdata = 32'h0;
    rsp0_err   = 1'b0;
    rsp1_valid = 1'b0;
    rsp1_rdata = 32'h0;
    rsp1_err   = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = accept_c & ~grant_c;
        req1_ready = accept_c & grant_c;
      end
      ACCESS: begin
        if (!err_c && we_q && size_q == 2'b10) begin
          ram_we    = 1'b1;
          ram_wdata = wdata_q;
        end
      end
      WRITE: begin
        // Merge uses the registered read word, never the live RAM output.
        ram_we    = 1'b1;
        ram_wdata = (size_q == 2'b00) ? {merge_q[31:8], wdata_q[7:0]}
                                      : {merge_q[31:16], wdata_q[15:0]};
      end
      RESP: begin
        if (grant_q) begin
          rsp1_valid = 1'b1;
          rsp1_rdata = rdata_q;
          rsp1_err   = err_q;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_rdata = rdata_q;
          rsp0_err   = err_q;
        end
      end
      default: ;
    endcase
  end

  // Request latch on grant, result capture in ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      merge_q      <= 32'h0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      if (accept_c) begin
        last_grant_q <= grant_c;
        grant_q      <= grant_c;
        we_q         <= grant_c ? req1_we    : req0_we;
        uns_q        <= grant_c ? req1_uns   : req0_uns;
        size_q       <= grant_c ? req1_size  : req0_size;
        addr_q       <= grant_c ? req1_addr  : req0_addr;
        wdata_q      <= grant_c ? req1_wdata : req0_wdata;
      end
      if (state_q == ACCESS) begin
        err_q   <= err_c;
        rdata_q <= (err_c || we_q) ? 32'h0 : load_c;
        merge_q <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte-array RAM plus a transaction-level
// reference model of sizes, extension, errors, latency and arbitration.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_we, req0_uns;
  logic [1:0]  req0_size;
  logic [31:0] req0_addr, req0_wdata;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_uns;
  logic [1:0]  req1_size;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;
  logic       init_done = 1'b0;
  logic [7:0] mem     [0:4095];
  logic [7:0] ref_mem [0:4095];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_size(req0_size), .req0_uns(req0_uns), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_size(req1_size), .req1_uns(req1_uns), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .rsp1_err(rsp1_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) ^ (i >> 4));
  endfunction

  // Byte-addressed RAM model; lanes outside the window read 0 and ignore writes.
  always_comb begin
    ram_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = ram_addr + 32'(i);
      if (a >= 32'h1000 && a <= 32'h1FFF) ram_rdata[8*i +: 8] = mem[int'(a - 32'h1000)];
    end
  end

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
    end else if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] a;
        a = ram_addr + 32'(i);
        if (a >= 32'h1000 && a <= 32'h1FFF) mem[int'(a - 32'h1000)] <= ram_wdata[8*i +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_size = sz; req0_uns = uns; req0_addr = a; req0_wdata = wd;
    end else begin
      req1_valid = v; req1_we = we; req1_size = sz; req1_uns = uns; req1_addr = a; req1_wdata = wd;
    end
  endtask

  function automatic logic ready_of(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic drop_valid(input int p);
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  // Transaction-level reference: result, latency and write-cycle pattern.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit apply,
                       output logic e, output logic [31:0] rd, output int lat,
                       output logic [3:0] wm);
    int nb;
    nb  = 1 << sz;
    e   = (sz == 2'b11) || ((a % 32'(nb)) != 0) || (a < 32'h1000) ||
          (longint'(a) + longint'(nb) - 1 > 64'h1FFF);
    rd  = 32'h0;
    lat = 2;
    wm  = 4'b0000;
    if (!e) begin
      if (we) begin
        if (apply)
          for (int i = 0; i < nb; i++) ref_mem[int'(a - 32'h1000) + i] = 8'(wd >> (8 * i));
        if (nb == 4) wm = 4'b0001;
        else begin wm = 4'b0010; lat = 3; end
      end else begin
        for (int i = 0; i < nb; i++) rd |= 32'(ref_mem[int'(a - 32'h1000) + i]) << (8 * i);
        if (!uns && nb == 1 && rd[7])  rd |= 32'hFFFF_FF00;
        if (!uns && nb == 2 && rd[15]) rd |= 32'hFFFF_0000;
      end
    end
  endtask

  // Observe the cycles after acceptance up to the expected response cycle.
  task automatic watch(input int p, input logic e, input logic [31:0] rd, input int lat,
                       input logic [3:0] wm);
    logic [3:0]  wo, ro;
    logic        oth, eo;
    logic [31:0] rdo;
    wo = '0; ro = '0; oth = 1'b0; eo = 1'b0; rdo = 32'h0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) drop_valid(p);
      #1;
      wo[k-1] = ram_we;
      ro[k-1] = (p == 0) ? rsp0_valid : rsp1_valid;
      oth    |= (p == 0) ? rsp1_valid : rsp0_valid;
      if (k == lat) begin
        rdo = (p == 0) ? rsp0_rdata : rsp1_rdata;
        eo  = (p == 0) ? rsp0_err   : rsp1_err;
      end
    end
    chk("ram_we_timing", 32'(wo), 32'(wm));
    chk("rsp_timing", 32'(ro), 32'(4'b0001 << (lat - 1)));
    chk("rsp_other_port", 32'(oth), 32'h0);
    chk("rsp_rdata", rdo, rd);
    chk("rsp_err", 32'(eo), 32'(e));
  endtask

  task automatic single(input int p, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic e;
    logic [31:0] rd;
    int lat;
    logic [3:0] wm;
    @(negedge clk);
    set_req(p, 1'b1, we, sz, uns, a, wd);
    #1;
    n = 0;
    while (ready_of(p) !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("ready", 32'(ready_of(p)), 32'h1);
    if (ready_of(p) !== 1'b1) begin
      drop_valid(p);
      return;
    end
    model(we, sz, uns, a, wd, 1'b1, e, rd, lat, wm);
    watch(p, e, rd, lat, wm);
  endtask

  initial begin
    int r0, r1, lg, gp, eg, n;
    logic e;
    logic [31:0] rd;
    int lat;
    logic [3:0] wm;

    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_flags", 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, ram_we}), 32'h0);
    chk("reset_ram_addr", ram_addr, 32'h0);
    chk("reset_ram_wdata", ram_wdata, 32'h0);
    chk("reset_rdata", rsp0_rdata | rsp1_rdata, 32'h0);
    init_done = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters contend with three word loads each.
    r0 = 3; r1 = 3; lg = 1;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      set_req(0, 1'(r0 > 0), 1'b0, 2'b10, 1'b0, 32'h1100 + 32'(4 * g), 32'h0);
      set_req(1, 1'(r1 > 0), 1'b0, 2'b10, 1'b0, 32'h1200 + 32'(4 * g), 32'h0);
      #1;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        @(negedge clk); #1; n++;
      end
      chk("contend_ready_any", 32'(req0_ready | req1_ready), 32'h1);
      chk("contend_ready_both", 32'(req0_ready & req1_ready), 32'h0);
      if (!(req0_ready || req1_ready)) continue;
      gp = req1_ready ? 1 : 0;
      eg = (r0 > 0 && r1 > 0) ? 1 - lg : ((r1 > 0) ? 1 : 0);
      lg = eg;
      chk("grant_order", 32'(gp), 32'(eg));
      if (gp == 0) r0--; else r1--;
      model(1'b0, 2'b10, 1'b0, (gp == 0) ? req0_addr : req1_addr, 32'h0, 1'b1, e, rd, lat, wm);
      watch(gp, e, rd, lat, wm);
    end

    // Directed word/byte accesses.
    single(0, 1'b1, 2'b10, 1'b0, 32'h1004, 32'hDEADBEEF);
    single(1, 1'b0, 2'b10, 1'b0, 32'h1004, 32'h0);
    single(0, 1'b1, 2'b00, 1'b0, 32'h1005, 32'h0000_0055);
    single(0, 1'b0, 2'b10, 1'b0, 32'h1004, 32'h0);
    single(1, 1'b1, 2'b00, 1'b0, 32'h1004, 32'h1234_5680);
    single(0, 1'b0, 2'b00, 1'b0, 32'h1004, 32'h0);
    single(0, 1'b0, 2'b00, 1'b1, 32'h1004, 32'h0);
    single(1, 1'b1, 2'b01, 1'b0, 32'h1FFE, 32'h0000_9ABC);
    single(1, 1'b0, 2'b01, 1'b0, 32'h1FFE, 32'h0);
    single(0, 1'b1, 2'b00, 1'b0, 32'h1FFF, 32'h0000_00C3);
    single(0, 1'b0, 2'b00, 1'b1, 32'h1FFF, 32'h0);

    // Error cases.
    single(0, 1'b0, 2'b10, 1'b0, 32'h1002, 32'h0);
    single(1, 1'b1, 2'b01, 1'b0, 32'h1001, 32'hFFFF_FFFF);
    single(0, 1'b1, 2'b10, 1'b0, 32'h0FFC, 32'h1111_1111);
    single(1, 1'b0, 2'b10, 1'b0, 32'h1FFE, 32'h0);
    single(0, 1'b1, 2'b11, 1'b0, 32'h1008, 32'h2222_2222);
    single(1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      int p;
      logic [1:0] sz;
      logic [31:0] a;
      p  = int'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       a = 32'h0FF0 + 32'($urandom_range(0, 15));
        1:       a = 32'h1FF0 + 32'($urandom_range(0, 31));
        default: begin
          a = 32'h1000 + 32'($urandom_range(0, 4095));
          if ($urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 32'h1);
        end
      endcase
      single(p, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    // Reset during the write cycle of a byte store.
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h1008, 32'h0000_00A5);
    #1;
    chk("rst_mid_ready", 32'(req0_ready), 32'h1);
    @(negedge clk);
    drop_valid(0);
    @(negedge clk); #1;
    chk("rst_mid_we_before", 32'(ram_we), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we_after", 32'(ram_we), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("rst_mid_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'h0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("rst_after_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'h0);
    end
    single(0, 1'b0, 2'b10, 1'b0, 32'h1008, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the byte-addressed data RAM (window 0x00001000–0x00001FFF). It shares the RAM's single 32-bit read/write port between requester 0 (the CPU load/store unit) and requester 1 (a DMA/debug port) using round-robin arbitration. It also performs size handling: byte/half/word loads with sign or zero extension. Because the RAM always writes four bytes, sub-word stores are done as read-modify-write. Alignment and range errors are reported back to the requester.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, address width on all ports
- RAM_BASE, 32'h00001000, lowest valid byte address
- RAM_TOP, 32'h00001FFF, highest valid byte address

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  request present (N = 0, 1)
- reqN_ready  out  1  request accepted this cycle
- reqN_we  in  1  1 = store, 0 = load
- reqN_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- reqN_uns  in  1  load zero-extends when 1, sign-extends when 0
- reqN_addr  in  ADDRESS_WIDTH  byte address
- reqN_wdata  in  32  store data, right-aligned
- rspN_valid  out  1  one-cycle response pulse
- rspN_rdata  out  32  extended load data, 0 for stores and errors
- rspN_err  out  1  misaligned, out-of-range or illegal size
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDRESS_WIDTH  RAM byte address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM combinational read data; byte at ram_addr in [7:0]

## Operation
- FSM states are IDLE, ACCESS, WRITE and RESP. Reset enters IDLE.
- IDLE:
  - If any reqN_valid is high, grant one requester and assert its reqN_ready combinationally for that cycle only.
  - Latch we, size, uns, addr, wdata and the grant index, then go to ACCESS.
- Arbitration is round-robin on a last_grant register.
  - When both requesters are valid, grant the one that is not last_grant.
  - last_grant resets to 1, so requester 0 wins the first contention.
  - last_grant updates on every grant.
- Error check happens in ACCESS and sets err if any of these holds:
  - size is 11;
  - size is half and addr[0] is 1;
  - size is word and addr[1:0] is nonzero;
  - addr is below RAM_BASE;
  - addr + bytes − 1 is above RAM_TOP.
  On error: no write, go to RESP.
- ACCESS, load: capture ram_rdata sized and extended into the response register, then go to RESP.
  - Byte uses [7:0]; half uses [15:0].
- ACCESS, word store: ram_we = 1 with ram_wdata = wdata, then go to RESP.
- ACCESS, sub-word store: capture ram_rdata into the merge register and go to WRITE.
- WRITE: ram_we = 1 with the merged data, then go to RESP.
  - Byte merge: {rdata[31:8], wdata[7:0]}.
  - Half merge: {rdata[31:16], wdata[15:0]}.
  - ram_wdata never depends combinationally on ram_rdata.
- RESP: pulse rspN_valid for the granted requester only, with rdata and err. Then go to IDLE.
- ram_addr is always driven from the latched address register.
- ram_we is high only in ACCESS (word store, no error) or WRITE.
- Byte lanes above RAM_TOP that are read or written by an RMW at 0x1FFD–0x1FFF are don't-care; the RAM ignores them.

## Timing
- Request accepted in cycle T (IDLE, ready = 1).
  - Load, word store or error: ram_we at T+1 for a word store; rsp_valid at T+2.
  - Sub-word store: RAM read at T+1, ram_we at T+2, rsp_valid at T+3.
- No new grant before the cycle after RESP.
  - Peak throughput is one access per 3 cycles, or 4 for sub-word stores.
- Requesters must hold valid and payload stable until ready. Payload is not needed after the ready cycle.
- Reset values: every output is 0. State is IDLE, last_grant is 1, and all latched registers are 0.
- Reset asserted mid-operation:
  - ram_we drops immediately (asynchronous).
  - A pending write is lost and the response is never issued.
  - The requester reissues after reset.

## Test plan
- Word store to 0x1004 with 0xDEADBEEF, then word load from 0x1004 → store rsp at T+2 with err = 0; load returns 0xDEADBEEF at T+2.
- After the above, byte store of 0x55 to 0x1005, then word load from 0x1004 → ram_we at T+2 only; load returns 0xDEAD55EF.
- Byte load from 0x1004 (memory 0x...80): uns = 0 returns 0xFFFFFF80; uns = 1 returns 0x00000080.
- Both requesters valid from reset, each with 3 loads → grants alternate 0,1,0,1,0,1; each rsp pulses only on the matching port.
- Error cases: word load from 0x1002, half store to 0x1001, word access to 0x0FFC, word access to 0x1FFE, and size 11 → err = 1, rdata = 0, ram_we never high.
- Assert rst_n low during WRITE of a byte store → ram_we falls the same instant; no rsp_valid; target word is unchanged when read back after reset.
